// File: rtl/instr_prefetch.sv
// instr_prefetch -- instruction prefetch unit with a small FIFO.
//
// The unit fetches sequential instruction words from a one-cycle-latency
// instruction memory and queues them in a FIFO for the consumer. A redirect
// flushes the queue, drops any response in flight, and restarts fetching at
// the new address after a one-cycle FLUSH bubble.
//
// Optional feature: define INSTR_PREFETCH_PERF_EN to add the fetch_count and
// flush_count performance counters as extra output ports.
//
// Parameters
//   XLEN      address / instruction width
//   DEPTH     FIFO entries, power of two, 2..64
//   RESET_PC  first fetch address after reset
//
// Ports
//   clk            clock, rising edge
//   reset_n        asynchronous active-low reset
//   imem_req       fetch request valid this cycle
//   imem_address   word-aligned fetch address
//   imem_data_out  instruction word, valid the cycle after its request
//   instr_valid    FIFO head holds an instruction
//   instr          FIFO head instruction
//   instr_pc       address of the FIFO head instruction
//   instr_ready    consumer accepts the head this cycle
//   redirect       flush and restart fetch
//   redirect_pc    restart address, bits [1:0] ignored
//   fetch_count    (perf build) issued requests, saturating
//   flush_count    (perf build) redirects seen, saturating
//
// state | meaning
// ------+-------------------------------------------------------------
// BOOT  | first cycle after reset release, no fetch yet
// RUN   | fetching while FIFO occupancy plus in-flight leaves room
// FLUSH | one-cycle bubble after a redirect, requests and data ignored
module instr_prefetch #(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'('h1000)
) (
  input  logic            clk,
  input  logic            reset_n,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_address,
  input  logic [XLEN-1:0] imem_data_out,
  output logic            instr_valid,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] instr_pc,
  input  logic            instr_ready,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc
`ifdef INSTR_PREFETCH_PERF_EN
  ,
  output logic [31:0]     fetch_count,
  output logic [31:0]     flush_count
`endif
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int OCC_W = CNT_W + 1;
  localparam logic [OCC_W-1:0] DEPTH_LIM = OCC_W'(DEPTH);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic [XLEN-1:0]   pc_q;
  logic              inflight_q;
  logic [XLEN-1:0]   inflight_pc_q;
  logic [XLEN-1:0]   mem_instr [DEPTH];
  logic [XLEN-1:0]   mem_pc    [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q;
  logic [PTR_W-1:0]  rd_ptr_q;
  logic [CNT_W-1:0]  count_q;
  logic [OCC_W-1:0]  occupancy;
  logic              push;
  logic              pop;
  logic              unused_redirect_lsb;

  assign unused_redirect_lsb = ^redirect_pc[1:0];

  // Occupancy as seen at the start of the cycle plus the response that is
  // still on its way; a new request is only safe if that leaves a free slot.
  assign occupancy = {1'b0, count_q} + {{CNT_W{1'b0}}, inflight_q};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= BOOT;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    imem_req = 1'b0;
    case (state_q)
      BOOT: begin
        state_d = redirect ? FLUSH : RUN;
      end
      RUN: begin
        imem_req = (occupancy < DEPTH_LIM);
        if (redirect) begin
          state_d = FLUSH;
        end
      end
      FLUSH: begin
        state_d = redirect ? FLUSH : RUN;
      end
      default: begin
        state_d = BOOT;
      end
    endcase
  end

  assign imem_address = pc_q;

  // A response is written only if neither its request cycle nor its own
  // cycle saw a redirect; the request-cycle case is folded into inflight_q.
  assign push        = inflight_q && !redirect;
  assign instr_valid = (count_q != '0);
  assign pop         = instr_valid && instr_ready && !redirect;
  assign instr       = instr_valid ? mem_instr[rd_ptr_q] : '0;
  assign instr_pc    = instr_valid ? mem_pc[rd_ptr_q]    : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
    end else begin
      inflight_q    <= imem_req && !redirect;
      inflight_pc_q <= pc_q;
      if (redirect) begin
        pc_q <= {redirect_pc[XLEN-1:2], 2'b00};
      end else if (imem_req) begin
        pc_q <= pc_q + XLEN'(4);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_instr[i] <= '0;
        mem_pc[i]    <= '0;
      end
    end else if (redirect) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        mem_instr[wr_ptr_q] <= imem_data_out;
        mem_pc[wr_ptr_q]    <= inflight_pc_q;
        wr_ptr_q            <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

`ifdef INSTR_PREFETCH_PERF_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fetch_count <= '0;
      flush_count <= '0;
    end else begin
      if (imem_req && (fetch_count != 32'hFFFF_FFFF)) begin
        fetch_count <= fetch_count + 32'd1;
      end
      if (redirect && (flush_count != 32'hFFFF_FFFF)) begin
        flush_count <= flush_count + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_instr_prefetch.sv
module tb_instr_prefetch;

  logic        clk;
  logic        reset_n;
  logic        imem_req;
  logic [31:0] imem_address;
  logic [31:0] imem_data_out;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready;
  logic        redirect;
  logic [31:0] redirect_pc;
`ifdef INSTR_PREFETCH_PERF_EN
  logic [31:0] fetch_count;
  logic [31:0] flush_count;
`endif

  int total = 0;
  int bad   = 0;

  instr_prefetch #(
    .XLEN(32),
    .DEPTH(4),
    .RESET_PC(32'h1000)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .imem_req(imem_req),
    .imem_address(imem_address),
    .imem_data_out(imem_data_out),
    .instr_valid(instr_valid),
    .instr(instr),
    .instr_pc(instr_pc),
    .instr_ready(instr_ready),
    .redirect(redirect),
    .redirect_pc(redirect_pc)
`ifdef INSTR_PREFETCH_PERF_EN
    ,
    .fetch_count(fetch_count),
    .flush_count(flush_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory: word content derived from its address, one cycle late.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  always @(posedge clk) begin
    if (imem_req) imem_data_out <= mem_word(imem_address);
    else          imem_data_out <= 32'hDEAD_BEEF;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench in cycle 0 (BOOT) right after reset release.
  task automatic apply_reset(input logic rdy);
    reset_n     = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    instr_ready = rdy;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n     = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    instr_ready = 1'b1;
    tick();
    tick();
    total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL rst_req: got %b want 0", imem_req); end
    total++; if (imem_address !== 32'h1000) begin bad++; $display("FAIL rst_addr: got %h want 00001000", imem_address); end
    total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b want 0", instr_valid); end
    total++; if (instr !== 32'h0) begin bad++; $display("FAIL rst_instr: got %h want 00000000", instr); end
    total++; if (instr_pc !== 32'h0) begin bad++; $display("FAIL rst_pc: got %h want 00000000", instr_pc); end
    reset_n = 1'b1;
    total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL boot_req: got %b want 0", imem_req); end
  endtask

  task automatic test_stream();
    logic [31:0] exp_pc;
    apply_reset(1'b1);
    tick();
    total++; if (imem_req !== 1'b1 || imem_address !== 32'h1000) begin
      bad++; $display("FAIL stream_req1: got req=%b addr=%h want req=1 addr=00001000", imem_req, imem_address);
    end
    tick();
    total++; if (instr_valid !== 1'b0 || imem_address !== 32'h1004) begin
      bad++; $display("FAIL stream_c2: got valid=%b addr=%h want valid=0 addr=00001004", instr_valid, imem_address);
    end
    tick();
    exp_pc = 32'h1000;
    for (int i = 0; i < 6; i++) begin
      total++;
      if (instr_valid !== 1'b1 || instr_pc !== exp_pc || instr !== mem_word(exp_pc)) begin
        bad++;
        $display("FAIL stream_pop%0d: got valid=%b pc=%h instr=%h want valid=1 pc=%h instr=%h",
                 i, instr_valid, instr_pc, instr, exp_pc, mem_word(exp_pc));
      end
      exp_pc = exp_pc + 32'd4;
      tick();
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] addrs [8];
    int          nreq;
    int          got;
    logic [31:0] exp_pc;
    apply_reset(1'b0);
    nreq = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (imem_req) begin
        if (nreq < 8) addrs[nreq] = imem_address;
        nreq++;
      end
    end
    total++; if (nreq != 4) begin bad++; $display("FAIL bp_nreq: got %0d want 4", nreq); end
    for (int i = 0; i < 4 && i < nreq; i++) begin
      total++;
      if (addrs[i] !== 32'h1000 + 32'(4 * i)) begin
        bad++; $display("FAIL bp_addr%0d: got %h want %h", i, addrs[i], 32'h1000 + 32'(4 * i));
      end
    end
    total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL bp_req_low: got %b want 0", imem_req); end
    total++; if (instr_valid !== 1'b1 || instr_pc !== 32'h1000 || instr !== mem_word(32'h1000)) begin
      bad++; $display("FAIL bp_head: got valid=%b pc=%h instr=%h want valid=1 pc=00001000 instr=%h",
                      instr_valid, instr_pc, instr, mem_word(32'h1000));
    end
    tick();
    total++; if (instr_pc !== 32'h1000 || instr !== mem_word(32'h1000)) begin
      bad++; $display("FAIL bp_hold: got pc=%h instr=%h want pc=00001000 instr=%h", instr_pc, instr, mem_word(32'h1000));
    end
    instr_ready = 1'b1;
    exp_pc = 32'h1000;
    got = 0;
    for (int i = 0; i < 30 && got < 8; i++) begin
      if (instr_valid && instr_ready) begin
        total++;
        if (instr_pc !== exp_pc || instr !== mem_word(exp_pc)) begin
          bad++; $display("FAIL bp_drain%0d: got pc=%h instr=%h want pc=%h", got, instr_pc, instr, exp_pc);
        end
        exp_pc = exp_pc + 32'd4;
        got++;
      end
      tick();
    end
    total++; if (got < 8) begin bad++; $display("FAIL bp_drain_timeout: got %0d pops want 8", got); end
  endtask

  task automatic test_redirect();
    logic [31:0] exp_pc;
    int          got;
    apply_reset(1'b1);
    for (int i = 0; i < 6; i++) tick();
    redirect    = 1'b1;
    redirect_pc = 32'h2003;
    tick();
    redirect = 1'b0;
    total++; if (instr_valid !== 1'b0 || imem_req !== 1'b0) begin
      bad++; $display("FAIL redir_flush: got valid=%b req=%b want valid=0 req=0", instr_valid, imem_req);
    end
    tick();
    total++; if (imem_req !== 1'b1 || imem_address !== 32'h2000) begin
      bad++; $display("FAIL redir_req: got req=%b addr=%h want req=1 addr=00002000", imem_req, imem_address);
    end
    exp_pc = 32'h2000;
    got = 0;
    for (int i = 0; i < 12; i++) begin
      if (instr_valid && instr_ready) begin
        total++;
        if (instr_pc !== exp_pc || instr !== mem_word(exp_pc)) begin
          bad++; $display("FAIL redir_pop%0d: got pc=%h instr=%h want pc=%h", got, instr_pc, instr, exp_pc);
        end
        exp_pc = exp_pc + 32'd4;
        got++;
      end
      tick();
    end
    total++; if (got < 8) begin bad++; $display("FAIL redir_pop_count: got %0d want >=8", got); end
  endtask

  task automatic test_redirect_on_response();
    int first_cycle;
    logic [31:0] first_pc;
    apply_reset(1'b1);
    tick();
    tick();
    redirect    = 1'b1;
    redirect_pc = 32'h3000;
    tick();
    redirect = 1'b0;
    first_cycle = -1;
    first_pc    = 32'h0;
    for (int i = 3; i < 12; i++) begin
      if (instr_valid && first_cycle < 0) begin
        first_cycle = i;
        first_pc    = instr_pc;
      end
      tick();
    end
    total++; if (first_pc !== 32'h3000) begin
      bad++; $display("FAIL resp_drop_pc: got %h want 00003000", first_pc);
    end
    total++; if (first_cycle != 6) begin
      bad++; $display("FAIL resp_drop_cycle: got %0d want 6", first_cycle);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_pc;
    int          got;
    apply_reset(1'b1);
    for (int i = 0; i < 4; i++) tick();
    redirect    = 1'b1;
    redirect_pc = 32'h4000;
    tick();
    redirect_pc = 32'h5008;
    tick();
    redirect = 1'b0;
    total++; if (imem_req !== 1'b0 || instr_valid !== 1'b0) begin
      bad++; $display("FAIL b2b_flush: got req=%b valid=%b want 0 0", imem_req, instr_valid);
    end
    tick();
    total++; if (imem_req !== 1'b1 || imem_address !== 32'h5008) begin
      bad++; $display("FAIL b2b_req: got req=%b addr=%h want req=1 addr=00005008", imem_req, imem_address);
    end
    exp_pc = 32'h5008;
    got = 0;
    for (int i = 0; i < 8; i++) begin
      if (instr_valid && instr_ready) begin
        total++;
        if (instr_pc !== exp_pc) begin
          bad++; $display("FAIL b2b_pop%0d: got pc=%h want %h", got, instr_pc, exp_pc);
        end
        exp_pc = exp_pc + 32'd4;
        got++;
      end
      tick();
    end
    total++; if (got < 4) begin bad++; $display("FAIL b2b_pop_count: got %0d want >=4", got); end
  endtask

  task automatic test_wrap();
    logic [31:0] exp_pc;
    int          got;
    apply_reset(1'b1);
    tick();
    tick();
    redirect    = 1'b1;
    redirect_pc = 32'hFFFF_FFFA;
    tick();
    redirect = 1'b0;
    exp_pc = 32'hFFFF_FFF8;
    got = 0;
    for (int i = 0; i < 12 && got < 5; i++) begin
      if (instr_valid && instr_ready) begin
        total++;
        if (instr_pc !== exp_pc || instr !== mem_word(exp_pc)) begin
          bad++; $display("FAIL wrap_pop%0d: got pc=%h instr=%h want pc=%h", got, instr_pc, instr, exp_pc);
        end
        exp_pc = exp_pc + 32'd4;
        got++;
      end
      tick();
    end
    total++; if (got < 5) begin bad++; $display("FAIL wrap_pop_count: got %0d want 5", got); end
  endtask

  task automatic test_reset_midop();
    apply_reset(1'b0);
    for (int i = 0; i < 5; i++) tick();
    total++; if (instr_valid !== 1'b1) begin bad++; $display("FAIL midrst_pre: got valid=%b want 1", instr_valid); end
    reset_n = 1'b0;
    #1;
    total++; if (instr_valid !== 1'b0 || imem_req !== 1'b0 || imem_address !== 32'h1000) begin
      bad++; $display("FAIL midrst_async: got valid=%b req=%b addr=%h want 0 0 00001000", instr_valid, imem_req, imem_address);
    end
    tick();
    tick();
    instr_ready = 1'b1;
    reset_n = 1'b1;
    tick();
    total++; if (imem_req !== 1'b1 || imem_address !== 32'h1000) begin
      bad++; $display("FAIL midrst_req: got req=%b addr=%h want req=1 addr=00001000", imem_req, imem_address);
    end
    tick();
    total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL midrst_c2: got valid=%b want 0", instr_valid); end
    tick();
    total++; if (instr_valid !== 1'b1 || instr_pc !== 32'h1000 || instr !== mem_word(32'h1000)) begin
      bad++; $display("FAIL midrst_head: got valid=%b pc=%h instr=%h want valid=1 pc=00001000", instr_valid, instr_pc, instr);
    end
  endtask

`ifdef INSTR_PREFETCH_PERF_EN
  task automatic test_perf();
    apply_reset(1'b0);
    total++; if (fetch_count !== 32'd0 || flush_count !== 32'd0) begin
      bad++; $display("FAIL perf_reset: got fetch=%0d flush=%0d want 0 0", fetch_count, flush_count);
    end
    for (int i = 0; i < 8; i++) tick();
    redirect    = 1'b1;
    redirect_pc = 32'h6000;
    tick();
    redirect = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    redirect    = 1'b1;
    redirect_pc = 32'h7000;
    tick();
    redirect = 1'b0;
    tick();
    tick();
    tick();
    total++; if (fetch_count !== 32'd10 || flush_count !== 32'd2) begin
      bad++; $display("FAIL perf_counts: got fetch=%0d flush=%0d want 10 2", fetch_count, flush_count);
    end
  endtask
`endif

  initial begin
    reset_n       = 1'b0;
    redirect      = 1'b0;
    redirect_pc   = 32'h0;
    instr_ready   = 1'b0;
    imem_data_out = 32'h0;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_redirect_on_response();
    test_back_to_back();
    test_wrap();
    test_reset_midop();
`ifdef INSTR_PREFETCH_PERF_EN
    test_perf();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
